scan_bus_bridge: RTL and testbench

- On-chip end of the scan protocol: a synchronous 87-bit scan chain driven by the scan_phi/scan_phi_bar/scan_data_in/scan_load_chip/scan_load_chain/scan_id pins.
- Each scan_id toggle launches one single-beat write or read on the internal memory/control bus.
- Read data and a ready flag are captured for scan-out.
- Sits between the chip pads and the SRAM/control-register bus.

---
 rtl/scan_bus_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_scan_bus_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : scan_bus_bridge
//  Purpose  : On-chip end of an 87-bit (default) synchronous scan chain that
//             launches single-beat bus reads/writes on each scan_id toggle.
//  Options  : SCAN_BUS_TIMEOUT_EN - abandon a request after TIMEOUT_CYCLES.
//  Revision : 1.0 - initial release
// ============================================================================
module scan_bus_bridge #(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_phi,
    input  logic              scan_phi_bar,
    input  logic              scan_data_in,
    input  logic              scan_load_chip,
    input  logic              scan_load_chain,
    output logic              scan_data_out,
    input  logic              scan_id,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CHAIN_L   = 2 + ADDR_W + 2 * DATA_W + 1;
    localparam int WDATA_LSB = 2 + ADDR_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // Pad vector bit positions; edge-detected pads occupy the low four bits.
    localparam int P_PHI    = 0;
    localparam int P_PHIB   = 1;
    localparam int P_LCHIP  = 2;
    localparam int P_ID     = 3;
    localparam int P_DATA   = 4;
    localparam int P_LCHAIN = 5;

    logic [5:0]                   pad_in;
    logic [5:0]                   pad_s;
    logic [SYNC_STAGES-1:0][5:0]  sync_q, sync_d;
    logic [3:0]                   dly_q, dly_d;
    logic [3:0]                   edge_q, edge_d;

    logic                         phi_rise, phib_rise, lchip_rise, id_edge;

    logic                         master_q, master_d;
    logic [CHAIN_L-1:0]           chain_q, chain_d;
    logic                         sh_wen_q, sh_wen_d;
    logic                         sh_ren_q, sh_ren_d;
    logic [ADDR_W-1:0]            sh_addr_q, sh_addr_d;
    logic [DATA_W-1:0]            sh_wdata_q, sh_wdata_d;

    logic [0:0]                   state_q, state_d;
    logic                         mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]            mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]            rdata_cap_q, rdata_cap_d;
    logic                         ready_cap_q, ready_cap_d;

    logic                         launch_wr, launch_rd, launch;
    logic                         timeout_hit;

    assign pad_in = {scan_load_chain, scan_data_in, scan_id,
                     scan_load_chip, scan_phi_bar, scan_phi};
    assign pad_s  = sync_q[SYNC_STAGES-1];

    // Edge pulses are registered, adding one cycle after the synchronizer.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
        dly_d  = pad_s[3:0];
        edge_d = {pad_s[P_ID] ^ dly_q[P_ID], pad_s[2:0] & ~dly_q[2:0]};
    end

    assign phi_rise   = edge_q[P_PHI];
    assign phib_rise  = edge_q[P_PHIB];
    assign lchip_rise = edge_q[P_LCHIP];
    assign id_edge    = edge_q[P_ID];

    always_comb begin
        master_d   = master_q;
        chain_d    = chain_q;
        sh_wen_d   = sh_wen_q;
        sh_ren_d   = sh_ren_q;
        sh_addr_d  = sh_addr_q;
        sh_wdata_d = sh_wdata_q;
        if (phi_rise) begin
            master_d = pad_s[P_DATA];
        end
        if (phib_rise) begin
            if (pad_s[P_LCHAIN]) begin
                chain_d = {ready_cap_q, rdata_cap_q, sh_wdata_q, sh_addr_q, sh_ren_q, sh_wen_q};
            end else begin
                chain_d = {master_q, chain_q[CHAIN_L-1:1]};
            end
        end
        // Loads from the pre-update chain so a coincident shift does not leak in.
        if (lchip_rise) begin
            sh_wen_d   = chain_q[0];
            sh_ren_d   = chain_q[1];
            sh_addr_d  = chain_q[ADDR_W+1:2];
            sh_wdata_d = chain_q[WDATA_LSB +: DATA_W];
        end
    end

    assign launch_wr = id_edge & sh_wen_q;
    assign launch_rd = id_edge & ~sh_wen_q & sh_ren_q;
    assign launch    = launch_wr | launch_rd;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch) state_d = ST_REQ;
            ST_REQ:  if (mem_ack || timeout_hit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_req = (state_q == ST_REQ);
        busy    = (state_q == ST_REQ);
    end

`ifdef SCAN_BUS_TIMEOUT_EN
    localparam int              TO_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = DATA_W'(32'hBAD0_0BAD);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = (state_q == ST_REQ) ? to_cnt_q + TO_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_hit = (state_q == ST_REQ) && (to_cnt_q == TO_LAST) && !mem_ack;
`else
    assign timeout_hit = 1'b0;
    // TIMEOUT_CYCLES only shapes the timeout build.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_off
    end
`endif

    always_comb begin
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_cap_d = rdata_cap_q;
        ready_cap_d = ready_cap_q;
        if (state_q == ST_IDLE && launch) begin
            mem_we_d    = launch_wr;
            mem_addr_d  = sh_addr_q;
            mem_wdata_d = launch_wr ? sh_wdata_q : '0;
            ready_cap_d = 1'b0;
        end
        if (state_q == ST_REQ) begin
            if (mem_ack) begin
                ready_cap_d = 1'b1;
                if (!mem_we_q) begin
                    rdata_cap_d = mem_rdata;
                end
            end else if (timeout_hit) begin
`ifdef SCAN_BUS_TIMEOUT_EN
                rdata_cap_d = TIMEOUT_RDATA;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= '0;
            dly_q       <= '0;
            edge_q      <= '0;
            master_q    <= 1'b0;
            chain_q     <= '0;
            sh_wen_q    <= 1'b0;
            sh_ren_q    <= 1'b0;
            sh_addr_q   <= '0;
            sh_wdata_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_cap_q <= '0;
            ready_cap_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            dly_q       <= dly_d;
            edge_q      <= edge_d;
            master_q    <= master_d;
            chain_q     <= chain_d;
            sh_wen_q    <= sh_wen_d;
            sh_ren_q    <= sh_ren_d;
            sh_addr_q   <= sh_addr_d;
            sh_wdata_q  <= sh_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_cap_q <= rdata_cap_d;
            ready_cap_q <= ready_cap_d;
        end
    end

    assign scan_data_out = chain_q[0];
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_bus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_scan_bus_bridge
//  Purpose  : Self-checking bench for scan_bus_bridge; bus transactions are
//             scoreboarded, scan-out is compared against a chain model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scan_bus_bridge;

    localparam int ADDR_W         = 20;
    localparam int DATA_W         = 32;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 256;
    localparam int L              = 2 + ADDR_W + 2 * DATA_W + 1;
    localparam int WDATA_LSB      = 2 + ADDR_W;
    localparam int RDATA_LSB      = WDATA_LSB + DATA_W;
    localparam int SH_W           = WDATA_LSB + DATA_W;
    localparam int HOLD           = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              scan_phi = 1'b0, scan_phi_bar = 1'b0, scan_data_in = 1'b0;
    logic              scan_load_chip = 1'b0, scan_load_chain = 1'b0, scan_id = 1'b0;
    logic              scan_data_out;
    logic              mem_req, mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    scan_bus_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .scan_phi(scan_phi), .scan_phi_bar(scan_phi_bar),
        .scan_data_in(scan_data_in), .scan_load_chip(scan_load_chip),
        .scan_load_chain(scan_load_chain), .scan_data_out(scan_data_out),
        .scan_id(scan_id), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor / responder
    int                req_cur = 0, req_last = 0, req_count = 0, ack_delay = 0;
    bit                ack_en = 1'b0, force_ack = 1'b0;
    logic              req_prev = 1'b0;
    logic [DATA_W-1:0] rd_val = '0;

    always @(negedge clk) begin
        logic ack_now;
        txn_t e;
        ack_now = 1'b0;
        if (mem_req) begin
            if (!req_prev) begin
                req_cur = 0;
                req_count++;
                check("req_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("req_we", 128'(mem_we), 128'(e.we));
                    check("req_addr", 128'(mem_addr), 128'(e.addr));
                    check("req_wdata", 128'(mem_wdata), 128'(e.wdata));
                end
            end
            if (ack_en && req_cur == ack_delay) ack_now = 1'b1;
            req_cur++;
        end else if (req_prev) begin
            req_last = req_cur;
        end
        req_prev  = mem_req;
        mem_ack   = ack_now | force_ack;
        mem_rdata = rd_val;
    end

    // Model state
    logic [L-1:0]      chain_m = '0;
    logic [SH_W-1:0]   sh_m    = '0;
    logic              ready_m = 1'b0;
    logic [DATA_W-1:0] rdata_m = '0;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_phi();
        scan_phi = 1'b1; wait_neg(HOLD); scan_phi = 1'b0; wait_neg(HOLD);
    endtask

    task automatic pulse_phi_bar();
        scan_phi_bar = 1'b1; wait_neg(HOLD); scan_phi_bar = 1'b0; wait_neg(HOLD);
    endtask

    task automatic pulse_load_chip();
        scan_load_chip = 1'b1; wait_neg(HOLD); scan_load_chip = 1'b0; wait_neg(HOLD);
    endtask

    task automatic shift_vec(input logic [L-1:0] vin, output logic [L-1:0] vout);
        vout = '0;
        for (int i = 0; i < L; i++) begin
            vout[i]      = scan_data_out;
            scan_data_in = vin[i];
            pulse_phi();
            pulse_phi_bar();
        end
    endtask

    function automatic logic [L-1:0] pack(input logic wen, input logic ren,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] wd);
        return {1'b0, {DATA_W{1'b0}}, wd, addr, ren, wen};
    endfunction

    task automatic load_shadows(input string tag, input logic [L-1:0] vec);
        logic [L-1:0] out;
        shift_vec(vec, out);
        check(tag, 128'(out), 128'(chain_m));
        chain_m = vec;
        pulse_load_chip();
        sh_m = vec[SH_W-1:0];
    endtask

    task automatic scan_readout(input string tag);
        logic [L-1:0] out, rnd;
        scan_load_chain = 1'b1; wait_neg(HOLD);
        pulse_phi_bar();
        scan_load_chain = 1'b0; wait_neg(HOLD);
        chain_m = {ready_m, rdata_m, sh_m};
        for (int i = 0; i < L; i++) rnd[i] = 1'($urandom_range(0, 1));
        shift_vec(rnd, out);
        check({tag, "_vec"},   128'(out), 128'(chain_m));
        check({tag, "_ready"}, 128'(out[L-1]), 128'(ready_m));
        check({tag, "_rdata"}, 128'(out[RDATA_LSB +: DATA_W]), 128'(rdata_m));
        check({tag, "_ren"},   128'(out[1]), 128'(sh_m[1]));
        check({tag, "_addr"},  128'(out[ADDR_W+1:2]), 128'(sh_m[ADDR_W+1:2]));
        chain_m = rnd;
    endtask

    task automatic toggle_id();
        scan_id = ~scan_id;
    endtask

    task automatic wait_req_rise(input int budget);
        for (int i = 0; i < budget && !mem_req; i++) wait_neg(1);
        check("req_rise_in_time", 128'(mem_req), 128'(1));
    endtask

    task automatic wait_req_fall(input int budget);
        for (int i = 0; i < budget && mem_req; i++) wait_neg(1);
        check("req_fall_in_time", 128'(mem_req), 128'(0));
        wait_neg(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cnt;
        logic [L-1:0] pat, out;

        wait_neg(5);
        check("rst_mem_req",  128'(mem_req), 128'(0));
        check("rst_busy",     128'(busy), 128'(0));
        check("rst_sdo",      128'(scan_data_out), 128'(0));
        check("rst_mem_we",   128'(mem_we), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        rst_n = 1'b1;
        wait_neg(5);

        // Write with immediate ack, including launch latency
        load_shadows("wr_shift", pack(1'b1, 1'b0, 20'h00001, 32'h8765_4321));
        exp_q.push_back('{1'b1, 20'h00001, 32'h8765_4321});
        ack_en = 1'b1; ack_delay = 0;
        toggle_id();
        wait_neg(SYNC_STAGES + 1);
        check("req_latency_early", 128'(mem_req), 128'(0));
        wait_neg(1);
        check("req_latency_on", 128'(mem_req), 128'(1));
        check("busy_during_wr", 128'(busy), 128'(1));
        wait_req_fall(50);
        check("busy_after_wr", 128'(busy), 128'(0));
        check("wr_req_len", 128'(req_last), 128'(1));
        ready_m = 1'b1;

        // Read with ack held off five cycles
        load_shadows("rd_shift", pack(1'b0, 1'b1, 20'h00001, 32'h0));
        rd_val = 32'h8765_4321; ack_delay = 5;
        exp_q.push_back('{1'b0, 20'h00001, 32'h0});
        toggle_id();
        wait_req_rise(20);
        wait_req_fall(50);
        check("rd_req_len", 128'(req_last), 128'(6));
        rdata_m = 32'h8765_4321;
        scan_readout("rd_scan");

        // Plain shift of 0x5A pattern returns the previous chain contents
        for (int i = 0; i < L; i++) pat[i] = 1'((8'h5A >> (i % 8)) & 8'h01);
        shift_vec(pat, out);
        check("pattern_shift_out", 128'(out), 128'(chain_m));
        chain_m = pat;

        // wen=ren=0: toggle ignored, captures unchanged
        cnt = req_count;
        load_shadows("noop_shift", pack(1'b0, 1'b0, 20'h00002, 32'h1111_2222));
        toggle_id();
        wait_neg(20);
        check("noop_no_req", 128'(req_count), 128'(cnt));
        scan_readout("noop_scan");

        // wen and ren both set (write wins), second toggle while busy dropped
        load_shadows("dbl_shift", pack(1'b1, 1'b1, 20'hABCDE, 32'hCAFE_F00D));
        exp_q.push_back('{1'b1, 20'hABCDE, 32'hCAFE_F00D});
        ack_delay = 30;
        cnt = req_count;
        toggle_id();
        wait_req_rise(20);
        wait_neg(5);
        toggle_id();
        wait_req_fall(100);
        wait_neg(20);
        check("dbl_one_txn", 128'(req_count), 128'(cnt + 1));
        check("dbl_queue_empty", 128'(exp_q.size()), 128'(0));

        // Reset during REQ, then a late ack
        ack_en = 1'b0;
        load_shadows("rst_shift", pack(1'b0, 1'b1, 20'h00003, 32'h0));
        exp_q.push_back('{1'b0, 20'h00003, 32'h0});
        toggle_id();
        wait_req_rise(20);
        wait_neg(2);
        rst_n = 1'b0;
        wait_neg(1);
        check("midrst_mem_req", 128'(mem_req), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_sdo", 128'(scan_data_out), 128'(0));
        wait_neg(4);
        rst_n = 1'b1;
        force_ack = 1'b1; wait_neg(2); force_ack = 1'b0;
        wait_neg(5);
        check("late_ack_no_req", 128'(mem_req), 128'(0));
        chain_m = '0; sh_m = '0; ready_m = 1'b0; rdata_m = '0;
        scan_readout("postrst_scan");

`ifdef SCAN_BUS_TIMEOUT_EN
        // Read with no ack is abandoned after TIMEOUT_CYCLES
        load_shadows("to_shift", pack(1'b0, 1'b1, 20'h00004, 32'h0));
        exp_q.push_back('{1'b0, 20'h00004, 32'h0});
        toggle_id();
        wait_req_rise(20);
        wait_req_fall(TIMEOUT_CYCLES + 50);
        check("to_req_len", 128'(req_last), 128'(TIMEOUT_CYCLES));
        rdata_m = DATA_W'(32'hBAD0_0BAD);
        ready_m = 1'b0;
        scan_readout("to_scan");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
